// File: rtl/proof_addsub_arb.sv
// Round-robin sequencer sharing one modular add/sub engine among NREQ requesters.
// Optional WAIT-state timeout is built only when PROOF_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module proof_addsub_arb #(
    parameter int NREQ    = 4,
    parameter int W       = 256,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ-1:0]   mode_i,
    input  logic [NREQ*W-1:0] data_i,
    input  logic [NREQ*W-1:0] datb_i,
    input  logic [W-1:0]      modp_i,
    output logic [NREQ-1:0]   ack_o,
    output logic [W-1:0]      datc_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              eng_dstr_o,
    output logic              eng_mode_o,
    output logic [W-1:0]      eng_modp_o,
    output logic [W-1:0]      eng_data_o,
    output logic [W-1:0]      eng_datb_o,
    input  logic              eng_dend_i,
    input  logic [W-1:0]      eng_datc_i
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic          mode_q, mode_d;
    logic [W-1:0]  modp_q, modp_d;
    logic [W-1:0]  data_q, data_d;
    logic [W-1:0]  datb_q, datb_d;
    logic [W-1:0]  datc_q, datc_d;
    logic          pick_vld;
    logic [GW-1:0] pick;

`ifdef PROOF_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // First requester at or after the rotating pointer wins.
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!pick_vld && req_i[idx]) begin
                pick_vld = 1'b1;
                pick     = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        mode_d  = mode_q;
        modp_d  = modp_q;
        data_d  = data_q;
        datb_d  = datb_q;
        datc_d  = datc_q;
`ifdef PROOF_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick;
                    mode_d  = mode_i[pick];
                    modp_d  = modp_i;
                    data_d  = data_i[int'(pick)*W +: W];
                    datb_d  = datb_i[int'(pick)*W +: W];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef PROOF_ARB_TIMEOUT_EN
                cnt_d   = '0;
                err_d   = 1'b0;
`endif
            end
            S_WAIT: begin
                // A result arriving on the limit cycle still wins over the timeout.
                if (eng_dend_i) begin
                    datc_d  = eng_datc_i;
                    state_d = S_DONE;
                end
`ifdef PROOF_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    datc_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                ptr_d   = (gnt_q == GW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            mode_q  <= 1'b0;
            modp_q  <= '0;
            data_q  <= '0;
            datb_q  <= '0;
            datc_q  <= '0;
`ifdef PROOF_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            mode_q  <= mode_d;
            modp_q  <= modp_d;
            data_q  <= data_d;
            datb_q  <= datb_d;
            datc_q  <= datc_d;
`ifdef PROOF_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        ack_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            ack_o[k] = (state_q == S_DONE) && (gnt_q == GW'(k));
        end
    end

`ifdef PROOF_ARB_TIMEOUT_EN
    assign err_o = err_q && (state_q == S_DONE);
`else
    assign err_o = 1'b0;
`endif

    assign busy_o     = (state_q != S_IDLE);
    assign eng_dstr_o = (state_q == S_ISSUE);
    assign eng_mode_o = mode_q;
    assign eng_modp_o = modp_q;
    assign eng_data_o = data_q;
    assign eng_datb_o = datb_q;
    assign datc_o     = datc_q;

endmodule

// File: tb/tb_proof_addsub_arb.sv
// Scoreboard bench for proof_addsub_arb: requester, engine and monitor run as separate processes.
`timescale 1ns/1ps
module tb_proof_addsub_arb;
    localparam int NREQ = 4;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic [NREQ-1:0]   req_i = '0;
    logic [NREQ-1:0]   mode_i = '0;
    logic [NREQ*W-1:0] data_i = '0;
    logic [NREQ*W-1:0] datb_i = '0;
    logic [W-1:0]      modp_i = '0;
    logic [NREQ-1:0]   ack_o;
    logic [W-1:0]      datc_o;
    logic              err_o, busy_o, eng_dstr_o, eng_mode_o;
    logic [W-1:0]      eng_modp_o, eng_data_o, eng_datb_o;
    logic              eng_dend_i = 1'b0;
    logic [W-1:0]      eng_datc_i = '0;

    proof_addsub_arb #(.NREQ(NREQ), .W(W), .TIMEOUT(15)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .mode_i(mode_i),
        .data_i(data_i), .datb_i(datb_i), .modp_i(modp_i),
        .ack_o(ack_o), .datc_o(datc_o), .err_o(err_o), .busy_o(busy_o),
        .eng_dstr_o(eng_dstr_o), .eng_mode_o(eng_mode_o), .eng_modp_o(eng_modp_o),
        .eng_data_o(eng_data_o), .eng_datb_o(eng_datb_o),
        .eng_dend_i(eng_dend_i), .eng_datc_i(eng_datc_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           idx;
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    exp_t         expq[$];
    int           cnt[NREQ];
    logic [W-1:0] opa[NREQ];
    logic [W-1:0] opb[NREQ];
    logic         opm[NREQ];
    logic [W-1:0] pdir = 16'd11;
    bit           rnd_mode = 1'b0;
    bit           eng_rand = 1'b0;
    bit           eng_on = 1'b1;
    bit           stray = 1'b0;
    int           ref_ptr = 0;
    int           passed = 0;
    int           total = 0;
    logic [W-1:0] last_res = '0;
    int           ecnt = 0;
    logic [W-1:0] ea = '0, eb = '0, ep = 16'd1;
    logic         em = 1'b0;
    int           seq[$];

    // a op b mod p for operands already below p
    function automatic logic [W-1:0] modop(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] p, input logic m);
        int r;
        if (!m) r = (int'(a) + int'(b)) % int'(p);
        else    r = (int'(a) - int'(b) + int'(p)) % int'(p);
        return r[W-1:0];
    endfunction

    task automatic newop(input int k);
        opa[k] = W'($urandom_range(0, 32'h7fff));
        opb[k] = W'($urandom_range(0, 32'h7fff));
        opm[k] = 1'($urandom_range(0, 1));
    endtask

    // Requesters plus the reference arbiter: expected winner and result pushed at each grant.
    always @(negedge clk) begin : req_drv
        int   w;
        exp_t e;
        if (rst_i) begin
            for (int k = 0; k < NREQ; k++) cnt[k] = 0;
            req_i   = '0;
            expq.delete();
            ref_ptr = 0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (ack_o[k] && cnt[k] > 0) begin
                    cnt[k]--;
                    if (rnd_mode) newop(k);
                end
            end
            modp_i = rnd_mode ? (16'h8000 | W'($urandom_range(0, 32'h7fff))) : pdir;
            for (int k = 0; k < NREQ; k++) begin
                req_i[k]            = (cnt[k] > 0);
                mode_i[k]           = opm[k];
                data_i[k*W +: W]    = opa[k];
                datb_i[k*W +: W]    = opb[k];
            end
            if (!busy_o && req_i != '0) begin
                w = -1;
                for (int i = 0; i < NREQ; i++) begin
                    if (w < 0 && req_i[(ref_ptr + i) % NREQ]) w = (ref_ptr + i) % NREQ;
                end
                e.idx = w;
                e.res = modop(opa[w], opb[w], modp_i, opm[w]);
                e.err = 1'b0;
`ifdef PROOF_ARB_TIMEOUT_EN
                if (!eng_on) begin
                    e.res = '0;
                    e.err = 1'b1;
                end
`endif
                expq.push_back(e);
                ref_ptr = (w + 1) % NREQ;
            end
        end
    end

    // Engine model: done rises a fixed or random number of cycles after start.
    always @(negedge clk) begin : eng_model
        if (eng_dend_i) begin
            eng_dend_i = 1'b0;
            eng_datc_i = W'($urandom);
        end
        if (stray) begin
            eng_dend_i = 1'b1;
            eng_datc_i = 16'h00AA;
            stray      = 1'b0;
        end else if (eng_dstr_o && eng_on) begin
            ea   = eng_data_o;
            eb   = eng_datb_o;
            ep   = eng_modp_o;
            em   = eng_mode_o;
            ecnt = eng_rand ? int'($urandom_range(1, 6)) : 3;
        end else if (ecnt > 0) begin
            ecnt--;
            if (ecnt == 0) begin
                eng_dend_i = 1'b1;
                eng_datc_i = modop(ea, eb, ep, em);
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_i && ack_o != '0) begin
            total++;
            if (expq.size() == 0) begin
                $display("FAIL unexpected_ack got ack=%b datc=%h required no ack", ack_o, datc_o);
            end else begin
                e        = expq.pop_front();
                last_res = e.res;
                if (ack_o == (NREQ'(1) << e.idx) && datc_o == e.res && err_o == e.err)
                    passed++;
                else
                    $display("FAIL ack_result got ack=%b datc=%h err=%b required ack=%b datc=%h err=%b",
                             ack_o, datc_o, err_o, NREQ'(1) << e.idx, e.res, e.err);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got === req) passed++;
        else $display("FAIL %s got %h required %h", name, got, req);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int n, input int lim);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (n < lim && !seen) begin
            @(negedge clk);
            n++;
            if (ack_o != '0) seen = 1'b1;
        end
        if (!seen) n = -1;
    endtask

    task automatic wait_idle();
        bit ok;
        int s;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            s = 0;
            for (int k = 0; k < NREQ; k++) s += cnt[k];
            if (s == 0 && expq.size() == 0 && !busy_o) ok = 1'b1;
        end
        chk("drain_to_idle", 32'(ok), 32'd1);
    endtask

    task automatic order_chk();
        int n;
        for (int i = 0; i < seq.size(); i++) begin
            wait_ack(n, 100);
            chk("grant_order", 32'(ack_o), 32'(NREQ'(1) << seq[i]));
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step(2);
        rst_i = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, nb;
        bit seen;
        for (int k = 0; k < NREQ; k++) begin
            cnt[k] = 0; opa[k] = '0; opb[k] = '0; opm[k] = 1'b0;
        end
        step(3);
        chk("rst_ctrl", 32'({ack_o, busy_o, eng_dstr_o, err_o, eng_mode_o}), 32'd0);
        chk("rst_data", 32'(datc_o | eng_data_o | eng_datb_o | eng_modp_o), 32'd0);
        rst_i = 1'b0;

        // Single add request, fixed 3-cycle engine
        step(2);
        opa[0] = 16'd5; opb[0] = 16'd7; opm[0] = 1'b0;
        cnt[0] = 1;
        @(negedge clk);
        wait_ack(n, 30);
        chk("t1_latency", 32'(n), 32'd5);
        wait_idle();

        // Subtraction that wraps, busy window
        step(1);
        opa[2] = 16'd3; opb[2] = 16'd8; opm[2] = 1'b1;
        cnt[2] = 1;
        @(negedge clk);
        n = 0; nb = 0; seen = 1'b0;
        while (n < 30 && !seen) begin
            @(negedge clk);
            n++;
            if (busy_o) nb++;
            if (ack_o != '0) seen = 1'b1;
        end
        chk("t2_busy_cycles", 32'(nb), 32'd5);
        @(negedge clk);
        chk("t2_idle_after", 32'(busy_o), 32'd0);
        wait_idle();

        // Round robin from reset
        rnd_mode = 1'b1;
        for (int k = 0; k < NREQ; k++) newop(k);
        do_reset();
        cnt[0] = 2; cnt[1] = 1; cnt[2] = 1; cnt[3] = 1;
        seq = '{0, 1, 2, 3, 0};
        order_chk();
        wait_idle();
        step(1);
        cnt[1] = 2; cnt[3] = 1;
        seq = '{1, 3, 1};
        order_chk();
        wait_idle();

        // Reset during WAIT, engine done lands after reset
        step(1);
        cnt[0] = 1;
        step(3);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        step(6);
        chk("t4_datc_cleared", 32'(datc_o), 32'd0);
        chk("t4_idle", 32'(busy_o), 32'd0);
        cnt[0] = 1; cnt[2] = 1;
        seq = '{0, 2};
        order_chk();
        wait_idle();

        // Stray done while idle
        step(1);
        stray = 1'b1;
        step(4);
        chk("t6_datc_held", 32'(datc_o), 32'(last_res));
        chk("t6_idle", 32'(busy_o), 32'd0);

        // Random traffic with random engine latency
        eng_rand = 1'b1;
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (cnt[k] == 0 && $urandom_range(0, 1) == 1) cnt[k] = int'($urandom_range(1, 4));
            end
            step(int'($urandom_range(1, 25)));
        end
        wait_idle();

        // Engine that never answers
        eng_rand = 1'b0;
        eng_on   = 1'b0;
        step(1);
        cnt[1] = 1;
        @(negedge clk);
        wait_ack(n, 60);
`ifdef PROOF_ARB_TIMEOUT_EN
        chk("t5_timeout_latency", 32'(n), 32'd17);
        wait_idle();
`else
        chk("t5_no_ack", 32'(n), 32'hffff_ffff);
        chk("t5_stuck_busy", 32'(busy_o), 32'd1);
        do_reset();
`endif
        eng_on = 1'b1;
        step(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
